fft_frame_ctrl: RTL and testbench

Frame scheduler that sits between the 8-channel polyphase filter bank and the Xilinx FFT core. It programs the core's config channel once after reset. It then collects one sample per channel into a slot bank, accepting any subset of channels per cycle, and streams the completed frame to the core's input with full AXI-Stream backpressure and `tlast`. It also counts completed frames and core framing errors.

---
 rtl/fft_ctrl_pkg.sv | 21 ++
 rtl/fft_frame_ctrl_if.sv | 37 +++
 rtl/fft_slot_bank.sv | 48 ++++
 rtl/fft_frame_ctrl.sv | 112 +++++++++++
 tb/tb_fft_frame_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the FFT frame scheduler.
// Config word encodes transform direction in bit 0.
package fft_ctrl_pkg;

  localparam int FFT_NCH = 8;
  localparam int FFT_DW  = 32;

  localparam logic [7:0] CFG_FWD = 8'h01;
  localparam logic [7:0] CFG_INV = 8'h00;

  typedef enum logic [1:0] {
    CONFIG,
    COLLECT,
    STREAM
  } state_t;

  function automatic logic [7:0] cfg_word(input logic fwd);
    return fwd ? CFG_FWD : CFG_INV;
  endfunction

endpackage

// File: rtl/fft_frame_ctrl_if.sv
// Config and frame-data streams toward the FFT core.
// master = scheduler side, slave = core side.
interface fft_frame_ctrl_if
  import fft_ctrl_pkg::*;
#(
  parameter int DW = FFT_DW
);

  logic [7:0]    cfg_tdata;
  logic          cfg_tvalid;
  logic          cfg_tready;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;

  modport master (
    output cfg_tdata,
    output cfg_tvalid,
    input  cfg_tready,
    output s_tdata,
    output s_tvalid,
    input  s_tready,
    output s_tlast
  );

  modport slave (
    input  cfg_tdata,
    input  cfg_tvalid,
    output cfg_tready,
    input  s_tdata,
    input  s_tvalid,
    output s_tready,
    input  s_tlast
  );

endinterface

// File: rtl/fft_slot_bank.sv
// Per-channel sample slots with full flags.
// Clear drops only the flags; data is overwritten on next capture.
module fft_slot_bank
  import fft_ctrl_pkg::*;
#(
  parameter int NCH = FFT_NCH,
  parameter int DW  = FFT_DW,
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    we,
  input  logic [NCH*DW-1:0] din,
  input  logic              clr,
  input  logic [IW-1:0]     idx,
  output logic [DW-1:0]     rdata,
  output logic [NCH-1:0]    full,
  output logic              all_full,
  output logic              fill_done
);

  logic [DW-1:0] slot [NCH];

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
      for (int i = 0; i < NCH; i++) begin
        slot[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (we[i]) begin
          slot[i] <= din[i*DW +: DW];
          full[i] <= 1'b1;
        end
      end
      if (clr) begin
        full <= '0;
      end
    end
  end

  assign rdata     = slot[idx];
  assign all_full  = &full;
  // frame completes at this edge
  assign fill_done = &(full | we);

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame scheduler: one-shot core config, per-channel slot
// collection, then AXI-Stream frame delivery with tlast.
module fft_frame_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int NCH = FFT_NCH,
  parameter int DW  = FFT_DW,
  parameter bit FWD = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*DW-1:0] ch_tdata,
  input  logic [NCH-1:0]    ch_tvalid,
  output logic [NCH-1:0]    ch_tready,
  fft_frame_ctrl_if.master  io,
  input  logic              evt_tlast_unexpected,
  input  logic              evt_tlast_missing,
  output logic [15:0]       frame_cnt,
  output logic [7:0]        err_cnt,
  output logic              busy
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  state_t          state;
  logic            cfg_valid;
  logic [IW-1:0]   idx;
  logic [NCH-1:0]  full;
  logic [NCH-1:0]  we;
  logic [DW-1:0]   rdata;
  logic            all_full;
  logic            fill_done;
  logic            last;
  logic            beat;
  logic            clr;

  fft_slot_bank #(
    .NCH (NCH),
    .DW  (DW)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .din       (ch_tdata),
    .clr       (clr),
    .idx       (idx),
    .rdata     (rdata),
    .full      (full),
    .all_full  (all_full),
    .fill_done (fill_done)
  );

  assign ch_tready = (state == COLLECT) ? ~full : '0;
  assign we        = ch_tvalid & ch_tready;
  assign last      = (idx == IW'(NCH - 1));
  assign beat      = io.s_tvalid & io.s_tready;
  assign clr       = beat & last;
  assign busy      = (state != COLLECT);

  assign io.cfg_tdata  = cfg_word(FWD);
  assign io.cfg_tvalid = cfg_valid;
  assign io.s_tvalid   = (state == STREAM) & all_full;
  assign io.s_tdata    = (state == STREAM) ? rdata : '0;
  assign io.s_tlast    = (state == STREAM) & last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CONFIG;
      cfg_valid <= 1'b0;
      idx       <= '0;
      frame_cnt <= '0;
    end else begin
      unique case (state)
        CONFIG: begin
          if (cfg_valid && io.cfg_tready) begin
            cfg_valid <= 1'b0;
            state     <= COLLECT;
          end else begin
            cfg_valid <= 1'b1;
          end
        end
        COLLECT: begin
          if (fill_done) begin
            state <= STREAM;
          end
        end
        STREAM: begin
          if (beat) begin
            if (last) begin
              idx       <= '0;
              frame_cnt <= frame_cnt + 16'd1;
              state     <= COLLECT;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        default: state <= CONFIG;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if ((evt_tlast_unexpected | evt_tlast_missing)
                 && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl: config, collection,
// streaming with backpressure, mid-frame reset, error counter.
module tb_fft_frame_ctrl;
  import fft_ctrl_pkg::*;

  typedef struct {
    logic [7:0]  vld;
    logic [31:0] base;
    logic [31:0] d3;
    logic [7:0]  exp_rdy;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] ch_tdata;
  logic [7:0]   ch_tvalid;
  logic [7:0]   ch_tready;
  logic         evt_u;
  logic         evt_m;
  logic [15:0]  frame_cnt;
  logic [7:0]   err_cnt;
  logic         busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_beats [8];
  vec_t tbl [7];

  fft_frame_ctrl_if #(.DW(32)) io ();

  fft_frame_ctrl #(
    .NCH (8),
    .DW  (32),
    .FWD (1'b1)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .ch_tdata             (ch_tdata),
    .ch_tvalid            (ch_tvalid),
    .ch_tready            (ch_tready),
    .io                   (io.master),
    .evt_tlast_unexpected (evt_u),
    .evt_tlast_missing    (evt_m),
    .frame_cnt            (frame_cnt),
    .err_cnt              (err_cnt),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic set_data(input logic [31:0] base,
                          input logic [31:0] d3);
    for (int i = 0; i < 8; i++) begin
      ch_tdata[i*32 +: 32] = base + 32'(i);
    end
    ch_tdata[3*32 +: 32] = d3;
  endtask

  task automatic set_exp(input logic [31:0] base,
                         input logic [31:0] d3);
    for (int i = 0; i < 8; i++) begin
      exp_beats[i] = base + 32'(i);
    end
    exp_beats[3] = d3;
  endtask

  // Drain one frame; bp selects a 1,0,0,1 ready pattern.
  task automatic drain(input bit bp);
    int beats = 0;
    int cyc = 0;
    bit stalled = 0;
    logic [31:0] pd = '0;
    logic pl = 1'b0;
    while (beats < 8 && cyc < 200) begin
      io.s_tready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (io.s_tvalid) begin
        chk("stream_rdy", 32'(ch_tready), 32'h0);
        if (stalled) begin
          chk("hold_data", io.s_tdata, pd);
          chk("hold_last", 32'(io.s_tlast), 32'(pl));
        end
        if (io.s_tready) begin
          chk("beat_data", io.s_tdata, exp_beats[beats]);
          chk("beat_last", 32'(io.s_tlast), 32'(beats == 7));
          beats++;
          stalled = 0;
        end else begin
          stalled = 1;
          pd = io.s_tdata;
          pl = io.s_tlast;
        end
      end
      step();
      cyc++;
    end
    chk("beat_count", 32'(beats), 32'd8);
    chk("after_frame_vld", 32'(io.s_tvalid), 32'h0);
  endtask

  initial begin
    tbl[0] = '{vld: 8'h09, base: 32'h3000, d3: 32'hA, exp_rdy: 8'hFF};
    tbl[1] = '{vld: 8'h0A, base: 32'h3000, d3: 32'hB, exp_rdy: 8'hF6};
    tbl[2] = '{vld: 8'h0C, base: 32'h3000, d3: 32'hB, exp_rdy: 8'hF4};
    tbl[3] = '{vld: 8'h18, base: 32'h3000, d3: 32'hB, exp_rdy: 8'hF0};
    tbl[4] = '{vld: 8'h28, base: 32'h3000, d3: 32'hB, exp_rdy: 8'hE0};
    tbl[5] = '{vld: 8'h48, base: 32'h3000, d3: 32'hB, exp_rdy: 8'hC0};
    tbl[6] = '{vld: 8'h88, base: 32'h3000, d3: 32'hB, exp_rdy: 8'h80};

    rst = 1'b1;
    ch_tdata = '0;
    ch_tvalid = '0;
    evt_u = 1'b0;
    evt_m = 1'b0;
    io.cfg_tready = 1'b0;
    io.s_tready = 1'b0;
    step();
    step();
    chk("rst_cfg_vld", 32'(io.cfg_tvalid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);
    chk("rst_rdy", 32'(ch_tready), 32'h0);
    chk("rst_s_vld", 32'(io.s_tvalid), 32'h0);
    chk("rst_s_last", 32'(io.s_tlast), 32'h0);
    chk("rst_s_data", io.s_tdata, 32'h0);
    chk("rst_frame", 32'(frame_cnt), 32'h0);
    chk("rst_err", 32'(err_cnt), 32'h0);

    // config handshake held off for three cycles
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("cfg_vld", 32'(io.cfg_tvalid), 32'h1);
      chk("cfg_data", 32'(io.cfg_tdata), 32'h01);
      chk("cfg_rdy_off", 32'(ch_tready), 32'h0);
      if (k == 3) io.cfg_tready = 1'b1;
    end
    step();
    io.cfg_tready = 1'b0;
    chk("cfg_done", 32'(io.cfg_tvalid), 32'h0);
    chk("collect_busy", 32'(busy), 32'h0);
    chk("collect_rdy", 32'(ch_tready), 32'hFF);

    // simultaneous arrival
    set_data(32'h1000, 32'h1003);
    ch_tvalid = 8'hFF;
    step();
    ch_tvalid = 8'h00;
    chk("n1_s_vld", 32'(io.s_tvalid), 32'h1);
    set_exp(32'h1000, 32'h1003);
    drain(1'b0);
    chk("n9_rdy", 32'(ch_tready), 32'hFF);
    chk("frame_1", 32'(frame_cnt), 32'h1);

    // staggered arrival, channel 3 repeated
    for (int r = 0; r < 7; r++) begin
      chk("tbl_rdy", 32'(ch_tready), 32'(tbl[r].exp_rdy));
      chk("tbl_busy", 32'(busy), 32'h0);
      set_data(tbl[r].base, tbl[r].d3);
      ch_tvalid = tbl[r].vld;
      step();
    end
    ch_tvalid = 8'h08;
    chk("stag_rdy", 32'(ch_tready), 32'h0);
    chk("stag_busy", 32'(busy), 32'h1);
    set_exp(32'h3000, 32'hA);
    drain(1'b0);
    chk("frame_2", 32'(frame_cnt), 32'h2);
    chk("held_rdy", 32'(ch_tready), 32'hFF);
    step();
    chk("held_cap", 32'(ch_tready), 32'hF7);
    set_data(32'h4000, 32'hDEAD);
    ch_tvalid = 8'hFF;
    step();
    ch_tvalid = 8'h00;
    set_exp(32'h4000, 32'hB);
    drain(1'b1);
    chk("frame_3", 32'(frame_cnt), 32'h3);

    // reset after four beats
    set_data(32'h5000, 32'h5003);
    ch_tvalid = 8'hFF;
    step();
    ch_tvalid = 8'h00;
    io.s_tready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      chk("pre_rst_data", io.s_tdata, 32'h5000 + 32'(b));
      chk("pre_rst_last", 32'(io.s_tlast), 32'h0);
      step();
    end
    rst = 1'b1;
    step();
    chk("mid_rst_vld", 32'(io.s_tvalid), 32'h0);
    chk("mid_rst_last", 32'(io.s_tlast), 32'h0);
    chk("mid_rst_frame", 32'(frame_cnt), 32'h0);
    chk("mid_rst_cfg", 32'(io.cfg_tvalid), 32'h0);
    rst = 1'b0;
    step();
    chk("recfg_vld", 32'(io.cfg_tvalid), 32'h1);
    chk("recfg_data", 32'(io.cfg_tdata), 32'h01);
    io.cfg_tready = 1'b1;
    step();
    io.cfg_tready = 1'b0;
    chk("recfg_done", 32'(io.cfg_tvalid), 32'h0);
    chk("recfg_rdy", 32'(ch_tready), 32'hFF);
    set_data(32'h6000, 32'h6003);
    ch_tvalid = 8'hFF;
    step();
    ch_tvalid = 8'h00;
    set_exp(32'h6000, 32'h6003);
    drain(1'b0);
    chk("frame_after_rst", 32'(frame_cnt), 32'h1);

    // error counter
    evt_u = 1'b1;
    evt_m = 1'b1;
    step();
    evt_u = 1'b0;
    evt_m = 1'b0;
    chk("err_both", 32'(err_cnt), 32'h1);
    evt_m = 1'b1;
    for (int c = 0; c < 100; c++) step();
    chk("err_101", 32'(err_cnt), 32'd101);
    for (int c = 0; c < 200; c++) step();
    evt_m = 1'b0;
    step();
    chk("err_sat", 32'(err_cnt), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
